// File: rtl/muldiv_writeback_if.sv
// Bundle between the multiply/divide execute stage and its neighbours:
// instruction decode (start/op/register numbers) and the register bank
// (two combinational read ports, one synchronous write port).
interface muldiv_writeback_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic             start;
  logic [1:0]       op;
  logic [AW-1:0]    rn;
  logic [AW-1:0]    rm;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    A1;
  logic [AW-1:0]    A2;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;
  logic             WE3;
  logic [AW-1:0]    A3;
  logic [WIDTH-1:0] WD3;
  logic             busy;
  logic             done;
  logic             dz;
  logic             err;

  // Environment side: decode issues requests, the bank returns read data.
  modport master (
    output start, op, rn, rm, rd, RD1, RD2,
    input  A1, A2, WE3, A3, WD3, busy, done, dz, err
  );

  // Execute stage side.
  modport slave (
    input  start, op, rn, rm, rd, RD1, RD2,
    output A1, A2, WE3, A3, WD3, busy, done, dz, err
  );
endinterface

// File: rtl/muldiv_writeback.sv
// Iterative multiply/divide execute stage. Reads two operands from the
// register bank, runs WIDTH shift-add (multiply) or restoring (divide)
// iterations, then writes the selected half of the result back through
// the bank write port. Latency from accepting edge to write edge is
// fixed at WIDTH+2 edges, including divide-by-zero.
module muldiv_writeback #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_writeback_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_e;

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IT  = CW'(WIDTH - 1);
  // r15 is the PC; it is written only by the fetch path, never from here.
  localparam logic [AW-1:0] PC_REG   = AW'(15);

  state_e           state_q, state_d;

  // Request latched at acceptance; drives the bank read addresses.
  logic [1:0]       op_q;
  logic [AW-1:0]    rn_q, rm_q, rd_q;

  // Shared datapath registers.
  //  multiply: {hi,lo} is the running product, lo starts as the multiplier,
  //            b holds the multiplicand.
  //  divide:   hi is the partial remainder, lo shifts the dividend out and
  //            the quotient in, b holds the divisor.
  //  div by 0: hi=dividend, lo=all-ones, iterations skipped, so the usual
  //            hi/lo result selection yields the defined values.
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic             dz_q, err_q;
  logic [AW-1:0]    a3_q;
  logic [WIDTH-1:0] wd3_q;

  // One-iteration results.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] hi_step, lo_step;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: fixed sequence, start only honoured in IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start)        state_d = S_READ;
      S_READ:                       state_d = S_EXEC;
      S_EXEC: if (cnt_q == LAST_IT) state_d = S_WB;
      S_WB:                         state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // Moore outputs; decoded from state so reset drops them asynchronously.
  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_WB);
    bus.WE3  = (state_q == S_WB) && (rd_q != PC_REG);
  end

  // Single multiply or divide iteration on the current hi/lo/b contents.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_rem  = {hi_q, lo_q[WIDTH-1]};
    div_ge   = (div_rem >= {1'b0, b_q});
    // Only consumed when div_ge, where the true difference is below b.
    div_diff = div_rem[WIDTH-1:0] - b_q;
    hi_step  = hi_q;
    lo_step  = lo_q;
    if (!dz_q) begin
      if (op_q[1]) begin
        hi_step = div_ge ? div_diff : div_rem[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], div_ge};
      end else begin
        hi_step = mul_sum[WIDTH:1];
        lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // Request latch, operand capture, iteration and writeback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      rn_q  <= '0;
      rm_q  <= '0;
      rd_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
      err_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            rn_q  <= bus.rn;
            rm_q  <= bus.rm;
            rd_q  <= bus.rd;
            dz_q  <= 1'b0;
            err_q <= 1'b0;
          end
        end
        S_READ: begin
          cnt_q <= '0;
          if (op_q[1]) begin
            b_q <= bus.RD2;
            if (bus.RD2 == '0) begin
              dz_q <= 1'b1;
              hi_q <= bus.RD1;
              lo_q <= '1;
            end else begin
              hi_q <= '0;
              lo_q <= bus.RD1;
            end
          end else begin
            b_q  <= bus.RD1;
            hi_q <= '0;
            lo_q <= bus.RD2;
          end
        end
        S_EXEC: begin
          hi_q  <= hi_step;
          lo_q  <= lo_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IT) begin
            // op[0] picks the high half (UMUL hi / remainder).
            a3_q  <= rd_q;
            wd3_q <= op_q[0] ? hi_step : lo_step;
            err_q <= (rd_q == PC_REG);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.A1  = rn_q;
  assign bus.A2  = rm_q;
  assign bus.A3  = a3_q;
  assign bus.WD3 = wd3_q;
  assign bus.dz  = dz_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_muldiv_writeback.sv
// Directed bench for muldiv_writeback: a small register-bank model feeds
// RD1/RD2 and absorbs writes; table vectors run back to back, followed by
// hand sequences for rd==15 with an ignored start, and mid-op reset.
module tb_muldiv_writeback;

  localparam int WIDTH = 32;
  localparam int AW    = 4;

  typedef struct {
    logic [1:0]       op;
    logic [AW-1:0]    rn;
    logic [AW-1:0]    rm;
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] a;      // preload of r[rn]
    logic [WIDTH-1:0] b;      // preload of r[rm]
    logic [WIDTH-1:0] exp_wd;
    logic             exp_dz;
  } vec_t;

  logic clk;
  logic rst_n;

  logic [WIDTH-1:0] bank [16];
  int               n_checks;
  int               n_fail;
  int               wr_cnt;

  muldiv_writeback_if #(.WIDTH(WIDTH), .AW(AW)) bus_if ();

  muldiv_writeback #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  assign bus_if.RD1 = bank[bus_if.A1];
  assign bus_if.RD2 = bank[bus_if.A2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation from an IDLE cycle (called #1 after an edge or at a
  // negedge) and follow it through WB into the following IDLE cycle, so a
  // subsequent call is a back-to-back start. inject raises start during
  // EXEC cycle 5, which must be ignored.
  task automatic run_op(input vec_t v, input bit inject);
    int               lat;
    int               n_done;
    int               wr_before;
    bit               busy_ok;
    bit               exp_err;
    logic [WIDTH-1:0] r15_before;
    exp_err    = (v.rd == AW'(15));
    bank[v.rn] = v.a;
    bank[v.rm] = v.b;
    r15_before = bank[15];
    wr_before  = wr_cnt;
    bus_if.op    = v.op;
    bus_if.rn    = v.rn;
    bus_if.rm    = v.rm;
    bus_if.rd    = v.rd;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.op    = ~v.op;
    bus_if.rn    = ~v.rn;
    bus_if.rm    = ~v.rm;
    bus_if.rd    = ~v.rd;
    check("read_busy", bus_if.busy, 1'b1);
    check("read_A1", bus_if.A1, v.rn);
    check("read_A2", bus_if.A2, v.rm);
    check("accept_clears_dz_err", {bus_if.dz, bus_if.err}, 2'b00);
    lat     = -1;
    n_done  = 0;
    busy_ok = 1'b1;
    for (int j = 1; j <= WIDTH + 2; j++) begin
      @(posedge clk);
      #1;
      if (inject && j == 5) bus_if.start = 1'b1;
      if (inject && j == 6) bus_if.start = 1'b0;
      if (j <= WIDTH + 1 && !bus_if.busy) busy_ok = 1'b0;
      if (bus_if.WE3) begin
        bank[bus_if.A3] = bus_if.WD3;
        wr_cnt++;
      end
      if (bus_if.done) begin
        n_done++;
        if (lat < 0) begin
          lat = j;
          check("wb_WE3", bus_if.WE3, !exp_err);
          check("wb_A3", bus_if.A3, v.rd);
          check("wb_WD3", bus_if.WD3, v.exp_wd);
          check("wb_dz", bus_if.dz, v.exp_dz);
          check("wb_err", bus_if.err, exp_err);
        end
      end
    end
    check("latency", lat, WIDTH + 1);
    check("done_count", n_done, 1);
    check("busy_through_op", busy_ok, 1'b1);
    check("idle_busy", bus_if.busy, 1'b0);
    check("idle_WE3", bus_if.WE3, 1'b0);
    check("idle_A3_hold", bus_if.A3, v.rd);
    check("idle_WD3_hold", bus_if.WD3, v.exp_wd);
    check("idle_dz_hold", bus_if.dz, v.exp_dz);
    check("idle_err_hold", bus_if.err, exp_err);
    check("write_count", wr_cnt - wr_before, exp_err ? 0 : 1);
    if (exp_err) check("r15_untouched", bank[15], r15_before);
    else         check("bank_result", bank[v.rd], v.exp_wd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_A1"},   bus_if.A1,   '0);
    check({tag, "_A2"},   bus_if.A2,   '0);
    check({tag, "_A3"},   bus_if.A3,   '0);
    check({tag, "_WE3"},  bus_if.WE3,  1'b0);
    check({tag, "_WD3"},  bus_if.WD3,  '0);
    check({tag, "_busy"}, bus_if.busy, 1'b0);
    check({tag, "_done"}, bus_if.done, 1'b0);
    check({tag, "_dz"},   bus_if.dz,   1'b0);
    check({tag, "_err"},  bus_if.err,  1'b0);
  endtask

  vec_t vecs [13];
  vec_t v5;

  initial begin
    //            op     rn  rm  rd  a              b              exp_wd         dz
    vecs[0]  = '{2'b00, 1,  2,  9,  32'd7,         32'd6,         32'd42,        1'b0};
    vecs[1]  = '{2'b01, 1,  2,  3,  32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0};
    vecs[2]  = '{2'b00, 1,  2,  3,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{2'b10, 4,  5,  6,  32'd100,       32'd7,         32'd14,        1'b0};
    vecs[4]  = '{2'b11, 4,  5,  6,  32'd100,       32'd7,         32'd2,         1'b0};
    vecs[5]  = '{2'b10, 4,  5,  6,  32'd100,       32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{2'b11, 4,  5,  6,  32'd100,       32'd0,         32'd100,       1'b1};
    vecs[7]  = '{2'b01, 7,  7,  7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[8]  = '{2'b11, 8,  9,  8,  32'hDEAD_BEEF, 32'h10,        32'hF,         1'b0};
    vecs[9]  = '{2'b10, 10, 11, 12, 32'd5,         32'd9,         32'd0,         1'b0};
    vecs[10] = '{2'b11, 10, 11, 12, 32'd5,         32'd9,         32'd5,         1'b0};
    vecs[11] = '{2'b00, 13, 14, 0,  32'h1234_5678, 32'h100,       32'h3456_7800, 1'b0};
    vecs[12] = '{2'b01, 13, 14, 0,  32'h1234_5678, 32'h100,       32'h12,        1'b0};
    v5       = '{2'b00, 1,  2,  15, 32'd3,         32'd4,         32'd12,        1'b0};

    n_checks = 0;
    n_fail   = 0;
    wr_cnt   = 0;
    for (int i = 0; i < 16; i++) bank[i] = 32'h1000 + 32'(i);
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.op    = '0;
    bus_if.rn    = '0;
    bus_if.rm    = '0;
    bus_if.rd    = '0;

    // Reset state.
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", bus_if.busy, 1'b0);

    // Table vectors, issued back to back.
    for (int i = 0; i < 13; i++) run_op(vecs[i], 1'b0);

    // rd==15 with a start during EXEC cycle 5 that must be ignored.
    run_op(v5, 1'b1);

    // Reset at EXEC cycle 10: aborts with no write, outputs drop at once.
    begin
      int wr_before;
      bank[1]   = 32'd7;
      bank[2]   = 32'd6;
      bank[9]   = 32'h5A5A_5A5A;
      wr_before = wr_cnt;
      bus_if.op    = 2'b00;
      bus_if.rn    = 4'd1;
      bus_if.rm    = 4'd2;
      bus_if.rd    = 4'd9;
      bus_if.start = 1'b1;
      @(posedge clk);
      #1;
      bus_if.start = 1'b0;
      for (int j = 1; j <= 10; j++) begin
        @(posedge clk);
        #1;
      end
      check("pre_abort_busy", bus_if.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      for (int j = 0; j < 3; j++) begin
        @(posedge clk);
        #1;
        if (bus_if.WE3) begin
          bank[bus_if.A3] = bus_if.WD3;
          wr_cnt++;
        end
      end
      check("abort_no_write", wr_cnt - wr_before, 0);
      check("abort_bank_intact", bank[9], 32'h5A5A_5A5A);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end

    // Normal operation after the abort.
    run_op(vecs[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
